// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for an 8-point FFT core: gathers 8 complex samples, runs the
// core with a start/done handshake under a watchdog, then streams the 8 bins out.
module fft8_frame_ctrl #(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_real,
  input  logic [DW-1:0]   in_imag,
  output logic            core_start,
  output logic [8*DW-1:0] core_in_real,
  output logic [8*DW-1:0] core_in_imag,
  input  logic [8*DW-1:0] core_out_real,
  input  logic [8*DW-1:0] core_out_imag,
  input  logic            core_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_real,
  output logic [DW-1:0]   out_imag,
  output logic [2:0]      out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            timeout_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned NS  = 8;
  localparam int unsigned IW  = 3;
  localparam int unsigned WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NS - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t state, state_d;

  logic [DW-1:0]    inbuf_re  [NS];
  logic [DW-1:0]    inbuf_im  [NS];
  logic [DW-1:0]    outbuf_re [NS];
  logic [DW-1:0]    outbuf_im [NS];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [WDW-1:0]   wdog;

  logic in_take;
  logic out_take;
  logic capture;
  logic expire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_d  = state;
    in_take  = 1'b0;
    out_take = 1'b0;
    capture  = 1'b0;
    expire   = 1'b0;
    case (state)
      S_LOAD: begin
        if (in_valid) begin
          in_take = 1'b1;
          if (wr_idx == IDX_LAST) state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle still wins.
        if (core_done) begin
          capture = 1'b1;
          state_d = S_UNLOAD;
        end else if (wdog == WDOG_LAST) begin
          expire  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          out_take = 1'b1;
          if (rd_idx == IDX_LAST) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Sample buffers, indices, watchdog and status
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NS; k++) begin
        inbuf_re[k]  <= '0;
        inbuf_im[k]  <= '0;
        outbuf_re[k] <= '0;
        outbuf_im[k] <= '0;
      end
      wr_idx      <= '0;
      rd_idx      <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (in_take) begin
        inbuf_re[wr_idx] <= in_real;
        inbuf_im[wr_idx] <= in_imag;
        wr_idx           <= (wr_idx == IDX_LAST) ? '0 : wr_idx + IW'(1);
      end
      if (state == S_START) begin
        wdog <= '0;
      end else if (state == S_WAIT) begin
        wdog <= wdog + WDW'(1);
      end
      if (capture) begin
        for (int unsigned k = 0; k < NS; k++) begin
          outbuf_re[k] <= core_out_real[DW*k +: DW];
          outbuf_im[k] <= core_out_imag[DW*k +: DW];
        end
      end
      if (expire) begin
        timeout_err <= 1'b1;
      end
      if (out_take) begin
        if (rd_idx == IDX_LAST) begin
          rd_idx    <= '0;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end else begin
          rd_idx <= rd_idx + IW'(1);
        end
      end
    end
  end

  // Core inputs follow the load buffer, which only changes during LOAD.
  for (genvar k = 0; k < NS; k++) begin : g_pack
    assign core_in_real[DW*k +: DW] = inbuf_re[k];
    assign core_in_imag[DW*k +: DW] = inbuf_im[k];
  end

  assign in_ready   = (state == S_LOAD) && !rst;
  assign core_start = (state == S_START);
  assign out_valid  = (state == S_UNLOAD);
  assign out_real   = outbuf_re[rd_idx];
  assign out_imag   = outbuf_im[rd_idx];
  assign out_idx    = rd_idx;
  assign out_last   = (state == S_UNLOAD) && (rd_idx == IDX_LAST);
  assign busy       = (state != S_LOAD) || (wr_idx != '0);

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl; the FFT core is replaced by hand-set
// result vectors and a done strobe driven from the main sequence.
module tb_fft8_frame_ctrl;

  localparam int unsigned DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_real;
  logic [DW-1:0]   in_imag;
  logic            core_start;
  logic [8*DW-1:0] core_in_real;
  logic [8*DW-1:0] core_in_imag;
  logic [8*DW-1:0] core_out_real;
  logic [8*DW-1:0] core_out_imag;
  logic            core_done;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_real;
  logic [DW-1:0]   out_imag;
  logic [2:0]      out_idx;
  logic            out_last;
  logic            busy;
  logic            timeout_err;
  logic [15:0]     frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] cre [8];
  logic [DW-1:0] cim [8];

  fft8_frame_ctrl #(.DW(16), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .core_start(core_start), .core_in_real(core_in_real), .core_in_imag(core_in_imag),
    .core_out_real(core_out_real), .core_out_imag(core_out_imag), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] re, input logic [DW-1:0] im);
    int n = 0;
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("push_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic set_core();
    for (int k = 0; k < 8; k++) begin
      core_out_real[16*k +: 16] = cre[k];
      core_out_imag[16*k +: 16] = cim[k];
    end
  endtask

  task automatic unload_all();
    for (int i = 0; i < 8; i++) begin
      chk("unl_valid", 128'(out_valid), 128'(1));
      chk("unl_idx",   128'(out_idx),   128'(i));
      chk("unl_real",  128'(out_real),  128'(cre[i]));
      chk("unl_imag",  128'(out_imag),  128'(cim[i]));
      chk("unl_last",  128'(out_last),  128'(i == 7));
      step();
    end
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
    core_done = 1'b0; core_out_real = '0; core_out_imag = '0; out_ready = 1'b1;

    // Reset values
    step(); step();
    chk("rst_in_ready",  128'(in_ready),    128'(0));
    chk("rst_start",     128'(core_start),  128'(0));
    chk("rst_out_valid", 128'(out_valid),   128'(0));
    chk("rst_terr",      128'(timeout_err), 128'(0));
    chk("rst_fcnt",      128'(frame_cnt),   128'(0));
    chk("rst_busy",      128'(busy),        128'(0));
    rst = 1'b0;
    step();
    chk("idle_in_ready", 128'(in_ready), 128'(1));

    // Basic frame: real k+1, core returns inputs reversed
    for (int k = 0; k < 8; k++) push(16'(k + 1), 16'h0000);
    chk("b_start",   128'(core_start), 128'(1));
    chk("b_inrdy",   128'(in_ready),   128'(0));
    chk("b_busy",    128'(busy),       128'(1));
    chk("b_core_re", core_in_real, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    for (int k = 0; k < 8; k++) begin cre[k] = 16'(8 - k); cim[k] = 16'h0000; end
    set_core();
    step();
    chk("b_start_1cyc", 128'(core_start), 128'(0));
    step(); step(); step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    unload_all();
    chk("b_fcnt",    128'(frame_cnt), 128'(1));
    chk("b_ovalid0", 128'(out_valid), 128'(0));
    chk("b_inrdy1",  128'(in_ready),  128'(1));

    // Gapped input, done/expiry race, then backpressure on bin 3
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b0;
      step();
      push(16'(k + 1), 16'(16'h0100 + k));
      if (k < 7) chk("g_no_start", 128'(core_start), 128'(0));
    end
    chk("g_start",   128'(core_start), 128'(1));
    chk("g_core_re", core_in_real, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("g_core_im", core_in_imag, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    step();
    repeat (14) step();
    chk("r_wait_ovalid", 128'(out_valid), 128'(0));
    step();
    chk("r_terr_pre", 128'(timeout_err), 128'(0));
    for (int k = 0; k < 8; k++) begin cre[k] = 16'(16'h0A00 + k); cim[k] = 16'(16'h0B00 + k); end
    set_core();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("r_unload",    128'(out_valid),   128'(1));
    chk("r_terr_post", 128'(timeout_err), 128'(0));
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        out_ready = 1'b0;
        repeat (3) begin
          chk("bp_idx",  128'(out_idx),   128'(3));
          chk("bp_real", 128'(out_real),  128'(16'h0A03));
          chk("bp_fcnt", 128'(frame_cnt), 128'(1));
          step();
        end
        out_ready = 1'b1;
      end
      chk("bp_seq_idx",  128'(out_idx),  128'(i));
      chk("bp_seq_real", 128'(out_real), 128'(cre[i]));
      chk("bp_seq_imag", 128'(out_imag), 128'(cim[i]));
      if (i == 7) chk("bp_fcnt_pre", 128'(frame_cnt), 128'(1));
      step();
    end
    chk("bp_fcnt_post", 128'(frame_cnt), 128'(2));
    chk("bp_ovalid0",   128'(out_valid), 128'(0));

    // Watchdog: core never answers
    for (int k = 0; k < 8; k++) push(16'(16'h0040 + k), 16'h0000);
    chk("w_start", 128'(core_start), 128'(1));
    step();
    n = 0;
    seen = 1'b0;
    while (!in_ready && n < 40) begin
      seen |= out_valid;
      n++;
      step();
    end
    chk("w_wait_cycles", 128'(n),           128'(16));
    chk("w_terr",        128'(timeout_err), 128'(1));
    chk("w_fcnt",        128'(frame_cnt),   128'(2));
    chk("w_no_out",      128'(seen),        128'(0));
    chk("w_busy",        128'(busy),        128'(0));

    // Next good frame after a timeout
    for (int k = 0; k < 8; k++) push(16'(k + 1), 16'h0000);
    for (int k = 0; k < 8; k++) begin cre[k] = 16'(16'h0050 + k); cim[k] = 16'(16'h0060 + k); end
    set_core();
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    unload_all();
    chk("n_terr_sticky", 128'(timeout_err), 128'(1));
    chk("n_fcnt",        128'(frame_cnt),   128'(3));

    // Reset after 5 samples loaded
    for (int k = 0; k < 5; k++) push(16'(16'h0020 + k), 16'h0000);
    chk("m_busy_pre", 128'(busy), 128'(1));
    rst = 1'b1;
    step();
    chk("m_inrdy",  128'(in_ready),    128'(0));
    chk("m_busy",   128'(busy),        128'(0));
    chk("m_terr",   128'(timeout_err), 128'(0));
    chk("m_fcnt",   128'(frame_cnt),   128'(0));
    chk("m_corere", core_in_real,      128'(0));
    rst = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      push(16'(16'h0030 + k), 16'h0000);
      if (k < 7) chk("m_no_start", 128'(core_start), 128'(0));
    end
    chk("m_start",   128'(core_start), 128'(1));
    chk("m_core_re", core_in_real, 128'h0037_0036_0035_0034_0033_0032_0031_0030);
    for (int k = 0; k < 8; k++) begin cre[k] = 16'(16'h0070 + k); cim[k] = 16'(16'h0080 + k); end
    set_core();
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;

    // Reset during unload at bin 4
    for (int i = 0; i < 4; i++) begin
      chk("u_real", 128'(out_real), 128'(cre[i]));
      step();
    end
    chk("u_idx4", 128'(out_idx), 128'(4));
    rst = 1'b1;
    step();
    chk("u_ovalid", 128'(out_valid), 128'(0));
    chk("u_oreal",  128'(out_real),  128'(0));
    chk("u_oidx",   128'(out_idx),   128'(0));
    chk("u_fcnt",   128'(frame_cnt), 128'(0));
    chk("u_inrdy",  128'(in_ready),  128'(0));
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step();
      seen |= core_start | out_valid;
    end
    chk("u_no_stale", 128'(seen),     128'(0));
    chk("u_inrdy1",   128'(in_ready), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
